core_reset_seq: RTL and testbench
=================================

Name: core_reset_seq

Overview:
- Reset and restart sequencer for the ACoreChip core instance on the ULX3S top.
- Replaces driving the core reset directly from the JTAG TRSTn pin.
- Synchronizes the asynchronous reset requests (JTAG TRSTn, user button) and holds the core in reset for a programmable time before release.
- Detects core faults and performs bounded automatic restarts with back-off; gives up into a latched HALTED state.

Parameters:
- SYNC_STAGES, 2, synchronizer depth for i_trstn and i_btn_reset (must be >= 2)
- HOLD_CYCLES, 250000, cycles the core is held in reset after all requests clear (must be >= 1)
- BACKOFF_CYCLES, 25000000, extra reset cycles after a fault before the hold phase (must be >= 1)
- FAULT_RETRY_MAX, 3, automatic restarts allowed before HALTED (must be >= 1)

Ports:
- i_clk_25mhz  in  1  system clock
- i_resetn  in  1  synchronous, active-low reset
- i_trstn  in  1  JTAG TRSTn pin, asynchronous, active-low request
- i_btn_reset  in  1  user button, asynchronous, active-high request
- i_core_fault  in  1  core fault flag, i_clk_25mhz domain
- o_core_reset  out  1  active-high reset to the core, registered
- o_ready  out  1  core running (state RUN)
- o_fault_latched  out  1  retries exhausted
- o_retry_cnt  out  $clog2(FAULT_RETRY_MAX+1)  faults since last user reset
- o_state  out  2  current state, for debug

Behaviour:
- Reset:
  - Applies when i_resetn=0 at an edge.
  - State becomes RESET_HOLD and the counter is cleared.
  - Outputs: o_core_reset=1, o_ready=0, o_fault_latched=0, o_retry_cnt=0.
  - Synchronizer flops reset to the "request active" value, so req_s=1 until inputs propagate.
- req_s = !trstn_sync | btn_sync.
  - Latency from pin to state change is SYNC_STAGES+1 edges.
- State encoding: RESET_HOLD=0, RUN=1, FAULT_WAIT=2, HALTED=3.
- o_core_reset=1 in every state except RUN. o_ready=1 only in RUN. Both are registered from the next-state value, so there is no glitch.
- RESET_HOLD:
  - req_s=1: counter cleared to 0.
  - Otherwise the counter increments.
  - When counter==HOLD_CYCLES-1 with req_s=0: next state RUN, counter cleared.
- RUN:
  - req_s=1: RESET_HOLD, o_retry_cnt cleared.
  - Else i_core_fault=1 and o_retry_cnt<FAULT_RETRY_MAX: FAULT_WAIT, o_retry_cnt+1.
  - Else i_core_fault=1: HALTED, o_fault_latched=1.
- FAULT_WAIT:
  - req_s=1: RESET_HOLD, retries cleared.
  - Else counter increments; at BACKOFF_CYCLES-1: RESET_HOLD, counter cleared, retries kept.
  - i_core_fault is ignored here (the core is in reset).
- HALTED:
  - Holds indefinitely.
  - req_s=1: RESET_HOLD, o_retry_cnt=0, o_fault_latched=0.
- Simultaneous events: req_s beats i_core_fault in the same cycle, and no retry is counted.
- Counter and retry width:
  - Shared counter width is $clog2(max(HOLD_CYCLES, BACKOFF_CYCLES)).
  - The counter never wraps; it is cleared on every state change.
  - o_retry_cnt saturates at FAULT_RETRY_MAX.
- i_resetn asserted in any state: all reset values on the next edge, including mid-count.

Optional Feature:
- Macro: RSTSEQ_AUTO_RETRY_EN.
- Defined: automatic retry behaves as described above.
- Undefined:
  - Any fault in RUN goes directly to HALTED with o_fault_latched=1.
  - FAULT_WAIT is unreachable; BACKOFF_CYCLES is unused and the counter is sized by HOLD_CYCLES only.
  - o_retry_cnt is tied to 0.

Decomposition:
- Package rstseq_pkg holds:
  - state encodings as localparams, plus STATE_W=2;
  - a max() constant function for counter sizing.
- One sub-module: cdc_sync, an N-stage synchronizer with parameterized reset value, instantiated twice (TRSTn with reset value 0, button with reset value 1).

Test Plan (SYNC_STAGES=2, HOLD_CYCLES=8, BACKOFF_CYCLES=4, FAULT_RETRY_MAX=2, RSTSEQ_AUTO_RETRY_EN defined):
- i_resetn low 3 cycles, i_trstn=1, i_btn_reset=0, then release (cycle 0 = first cycle with i_resetn=1) -> o_core_reset=1 through cycle 9, 0 and o_ready=1 from cycle 10.
- In RUN, 1-cycle i_btn_reset pulse -> o_core_reset rises 3 edges later, stays high 8 cycles after req_s clears, then RUN; o_retry_cnt=0.
- In RUN, 1-cycle i_core_fault -> o_core_reset high for 4+8=12 cycles, then RUN with o_retry_cnt=1. Second fault -> o_retry_cnt=2. Third fault -> state HALTED, o_fault_latched=1, o_core_reset held high for 1000 cycles.
- In HALTED, i_trstn low 2 cycles -> RESET_HOLD with o_retry_cnt=0 and o_fault_latched=0; RUN 8 cycles after req_s clears.
- i_core_fault and synchronized button request in the same cycle in RUN -> RESET_HOLD, o_retry_cnt=0, no FAULT_WAIT visited.
- i_resetn low during cycle 2 of FAULT_WAIT -> next edge: RESET_HOLD, counter 0, all outputs at reset values.

Source files
------------

// File: rtl/rstseq_pkg.sv
// Shared definitions for the core reset/restart sequencer: state
// encodings, the state type and a small helper for counter sizing.
package rstseq_pkg;

    localparam int STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_RESET_HOLD = 2'd0;
    localparam logic [STATE_W-1:0] ST_RUN        = 2'd1;
    localparam logic [STATE_W-1:0] ST_FAULT_WAIT = 2'd2;
    localparam logic [STATE_W-1:0] ST_HALTED     = 2'd3;

    typedef enum logic [STATE_W-1:0] {
        S_RESET_HOLD = ST_RESET_HOLD,
        S_RUN        = ST_RUN,
        S_FAULT_WAIT = ST_FAULT_WAIT,
        S_HALTED     = ST_HALTED
    } state_e;

    // Larger of two integers, used to size the shared hold/back-off counter.
    function automatic int max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/core_reset_seq_cdc_sync.sv
// N-stage synchronizer for a single asynchronous level. The reset value
// is a parameter so each instance can come out of reset reporting
// "request active" in its own polarity.
module cdc_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic resetn_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    // Shift the raw input through the flop chain; the last stage is the safe copy.
    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/core_reset_seq.sv
// Reset and restart sequencer for the core. Synchronizes the JTAG TRSTn
// and user-button reset requests, holds the core in reset for
// HOLD_CYCLES after they clear, and reacts to core faults.
// Optional feature macro: RSTSEQ_AUTO_RETRY_EN. When defined, a fault
// triggers a back-off plus re-hold, up to FAULT_RETRY_MAX times before
// HALTED. When undefined, any fault goes straight to HALTED.
module core_reset_seq
    import rstseq_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int HOLD_CYCLES     = 250000,
    parameter int BACKOFF_CYCLES  = 25000000,
    parameter int FAULT_RETRY_MAX = 3
) (
    input  logic                               i_clk_25mhz,
    input  logic                               i_resetn,
    input  logic                               i_trstn,
    input  logic                               i_btn_reset,
    input  logic                               i_core_fault,
    output logic                               o_core_reset,
    output logic                               o_ready,
    output logic                               o_fault_latched,
    output logic [$clog2(FAULT_RETRY_MAX+1)-1:0] o_retry_cnt,
    output logic [STATE_W-1:0]                 o_state
);

`ifdef RSTSEQ_AUTO_RETRY_EN
    localparam int CNT_MAX = max(HOLD_CYCLES, BACKOFF_CYCLES);
`else
    // Back-off is never used here; the term only keeps the parameter referenced.
    localparam int CNT_MAX = max(HOLD_CYCLES, 1 + 0 * BACKOFF_CYCLES);
`endif
    localparam int CNT_W_RAW = $clog2(CNT_MAX);
    localparam int CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;
    localparam int RETRY_W   = $clog2(FAULT_RETRY_MAX + 1);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    logic trstn_sync;
    logic btn_sync;
    logic req_s;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             flt_q, flt_d;
    logic             core_reset_q;
    logic             ready_q;

    cdc_sync #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b0)
    ) u_trstn_sync (
        .clk_i    (i_clk_25mhz),
        .resetn_i (i_resetn),
        .d_i      (i_trstn),
        .q_o      (trstn_sync)
    );

    cdc_sync #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_btn_sync (
        .clk_i    (i_clk_25mhz),
        .resetn_i (i_resetn),
        .d_i      (i_btn_reset),
        .q_o      (btn_sync)
    );

    // Either request source forces the core back into reset.
    assign req_s = !trstn_sync | btn_sync;

`ifdef RSTSEQ_AUTO_RETRY_EN
    localparam logic [CNT_W-1:0]   BACKOFF_LAST = CNT_W'(BACKOFF_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX_V  = RETRY_W'(FAULT_RETRY_MAX);

    logic [RETRY_W-1:0] retry_q, retry_d;
`endif

    // Next-state logic; a reset request always wins over a fault in the same cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        flt_d   = flt_q;
`ifdef RSTSEQ_AUTO_RETRY_EN
        retry_d = retry_q;
`endif
        case (state_q)
            S_RESET_HOLD: begin
                if (req_s) begin
                    cnt_d = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RUN: begin
                cnt_d = '0;
                if (req_s) begin
                    state_d = S_RESET_HOLD;
`ifdef RSTSEQ_AUTO_RETRY_EN
                    retry_d = '0;
`endif
                end else if (i_core_fault) begin
`ifdef RSTSEQ_AUTO_RETRY_EN
                    if (retry_q < RETRY_MAX_V) begin
                        state_d = S_FAULT_WAIT;
                        retry_d = retry_q + RETRY_W'(1);
                    end else begin
                        state_d = S_HALTED;
                        flt_d   = 1'b1;
                    end
`else
                    state_d = S_HALTED;
                    flt_d   = 1'b1;
`endif
                end
            end
`ifdef RSTSEQ_AUTO_RETRY_EN
            S_FAULT_WAIT: begin
                if (req_s) begin
                    state_d = S_RESET_HOLD;
                    cnt_d   = '0;
                    retry_d = '0;
                end else if (cnt_q == BACKOFF_LAST) begin
                    state_d = S_RESET_HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif
            S_HALTED: begin
                cnt_d = '0;
                if (req_s) begin
                    state_d = S_RESET_HOLD;
                    flt_d   = 1'b0;
`ifdef RSTSEQ_AUTO_RETRY_EN
                    retry_d = '0;
`endif
                end
            end
            default: begin
                state_d = S_RESET_HOLD;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and outputs; outputs come from the next state so they never glitch.
    always_ff @(posedge i_clk_25mhz) begin
        if (!i_resetn) begin
            state_q      <= S_RESET_HOLD;
            cnt_q        <= '0;
            flt_q        <= 1'b0;
            core_reset_q <= 1'b1;
            ready_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            flt_q        <= flt_d;
            core_reset_q <= (state_d != S_RUN);
            ready_q      <= (state_d == S_RUN);
        end
    end

`ifdef RSTSEQ_AUTO_RETRY_EN
    // Fault counter since the last user reset.
    always_ff @(posedge i_clk_25mhz) begin
        if (!i_resetn) begin
            retry_q <= '0;
        end else begin
            retry_q <= retry_d;
        end
    end

    assign o_retry_cnt = retry_q;
`else
    assign o_retry_cnt = '0;
`endif

    assign o_core_reset    = core_reset_q;
    assign o_ready         = ready_q;
    assign o_fault_latched = flt_q;
    assign o_state         = state_q;

endmodule

// File: tb/tb_core_reset_seq.sv
// Directed bench for core_reset_seq. Expected output snapshots are queued
// together with the number of cycles until they should appear, then
// popped and compared as the DUT runs.
module tb_core_reset_seq;

    localparam int SYNC_STAGES     = 2;
    localparam int HOLD_CYCLES     = 8;
    localparam int BACKOFF_CYCLES  = 4;
    localparam int FAULT_RETRY_MAX = 2;
    localparam int RW              = $clog2(FAULT_RETRY_MAX + 1);

    localparam logic [1:0] RH = 2'd0;
    localparam logic [1:0] RN = 2'd1;
    localparam logic [1:0] FW = 2'd2;
    localparam logic [1:0] HL = 2'd3;

    logic          clk = 1'b0;
    logic          resetn;
    logic          trstn;
    logic          btn;
    logic          fault;
    logic          coreReset;
    logic          ready;
    logic          faultLatched;
    logic [RW-1:0] retryCnt;
    logic [1:0]    state;

    typedef struct {
        string      tag;
        int         delay;
        logic [6:0] exp;
    } exp_t;

    exp_t sbQ[$];
    int   checks   = 0;
    int   failures = 0;

    core_reset_seq #(
        .SYNC_STAGES     (SYNC_STAGES),
        .HOLD_CYCLES     (HOLD_CYCLES),
        .BACKOFF_CYCLES  (BACKOFF_CYCLES),
        .FAULT_RETRY_MAX (FAULT_RETRY_MAX)
    ) dut (
        .i_clk_25mhz     (clk),
        .i_resetn        (resetn),
        .i_trstn         (trstn),
        .i_btn_reset     (btn),
        .i_core_fault    (fault),
        .o_core_reset    (coreReset),
        .o_ready         (ready),
        .o_fault_latched (faultLatched),
        .o_retry_cnt     (retryCnt),
        .o_state         (state)
    );

    // 25 MHz-style free-running clock.
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic rn, input logic tr, input logic bt, input logic fl);
        resetn = rn;
        trstn  = tr;
        btn    = bt;
        fault  = fl;
    endtask

    task automatic expectAfter(input string tag, input int delay, input logic [1:0] st,
                               input logic rst, input logic rdy, input logic flt,
                               input logic [1:0] rc);
        exp_t e;
        e.tag   = tag;
        e.delay = delay;
        e.exp   = {st, rst, rdy, flt, rc};
        sbQ.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t       e;
        logic [6:0] obs;
        while (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            repeat (e.delay) tick();
            obs = {state, coreReset, ready, faultLatched, 2'(retryCnt)};
            checks++;
            assert (obs === e.exp) else begin
                failures++;
                $error("[TB] FAIL %s: observed {st,rst,rdy,flt,retry}=%b expected=%b",
                       e.tag, obs, e.exp);
            end
        end
    endtask

`ifdef RSTSEQ_AUTO_RETRY_EN
    // One fault pulse in RUN: back-off, re-hold, and return to RUN with retry count r.
    task automatic runFaultRetry(input int r);
        applyStimulus(1, 1, 0, 1);
        tick();
        applyStimulus(1, 1, 0, 0);
        expectAfter("fw_enter",      0, FW, 1, 0, 0, 2'(r));
        expectAfter("fw_last",       3, FW, 1, 0, 0, 2'(r));
        expectAfter("fw_hold_start", 1, RH, 1, 0, 0, 2'(r));
        expectAfter("fw_hold_end",   7, RH, 1, 0, 0, 2'(r));
        expectAfter("fw_run",        1, RN, 0, 1, 0, 2'(r));
        checkOutput();
    endtask
`endif

    initial begin
        // Power-on reset, then the initial hold period.
        applyStimulus(0, 1, 0, 0);
        repeat (3) tick();
        expectAfter("reset_state", 0, RH, 1, 0, 0, 2'd0);
        checkOutput();
        applyStimulus(1, 1, 0, 0);
        expectAfter("boot_hold", 9, RH, 1, 0, 0, 2'd0);
        expectAfter("boot_run",  1, RN, 0, 1, 0, 2'd0);
        checkOutput();

        // Single-cycle button pulse while running.
        applyStimulus(1, 1, 1, 0);
        tick();
        applyStimulus(1, 1, 0, 0);
        expectAfter("btn_still_run",  1, RN, 0, 1, 0, 2'd0);
        expectAfter("btn_hold_start", 1, RH, 1, 0, 0, 2'd0);
        expectAfter("btn_hold_end",   7, RH, 1, 0, 0, 2'd0);
        expectAfter("btn_run",        1, RN, 0, 1, 0, 2'd0);
        checkOutput();

        // Faults until the sequencer gives up.
`ifdef RSTSEQ_AUTO_RETRY_EN
        runFaultRetry(1);
        runFaultRetry(2);
        applyStimulus(1, 1, 0, 1);
        tick();
        applyStimulus(1, 1, 0, 0);
        expectAfter("halt_enter", 0, HL, 1, 0, 1, 2'd2);
        for (int i = 0; i < 10; i++) expectAfter("halt_hold", 100, HL, 1, 0, 1, 2'd2);
        checkOutput();
`else
        applyStimulus(1, 1, 0, 1);
        tick();
        applyStimulus(1, 1, 0, 0);
        expectAfter("halt_enter", 0, HL, 1, 0, 1, 2'd0);
        for (int i = 0; i < 10; i++) expectAfter("halt_hold", 100, HL, 1, 0, 1, 2'd0);
        checkOutput();
`endif

        // TRSTn low for two cycles recovers from HALTED.
        applyStimulus(1, 0, 0, 0);
        tick();
        tick();
        applyStimulus(1, 1, 0, 0);
        expectAfter("trst_hold_start", 1, RH, 1, 0, 0, 2'd0);
        expectAfter("trst_hold_end",   8, RH, 1, 0, 0, 2'd0);
        expectAfter("trst_run",        1, RN, 0, 1, 0, 2'd0);
        checkOutput();

        // Fault coinciding with a synchronized button request: the request wins.
`ifdef RSTSEQ_AUTO_RETRY_EN
        runFaultRetry(1);
`endif
        applyStimulus(1, 1, 1, 0);
        tick();
        tick();
        applyStimulus(1, 1, 0, 1);
        tick();
        applyStimulus(1, 1, 0, 0);
        expectAfter("simul_hold",     0, RH, 1, 0, 0, 2'd0);
        expectAfter("simul_no_fw",    1, RH, 1, 0, 0, 2'd0);
        expectAfter("simul_hold_end", 7, RH, 1, 0, 0, 2'd0);
        expectAfter("simul_run",      1, RN, 0, 1, 0, 2'd0);
        checkOutput();

        // Synchronous reset in the middle of a count.
        applyStimulus(1, 1, 0, 1);
        tick();
        applyStimulus(1, 1, 0, 0);
`ifdef RSTSEQ_AUTO_RETRY_EN
        expectAfter("mid_fw_1", 0, FW, 1, 0, 0, 2'd1);
        expectAfter("mid_fw_2", 1, FW, 1, 0, 0, 2'd1);
`else
        expectAfter("mid_halt_1", 0, HL, 1, 0, 1, 2'd0);
        expectAfter("mid_halt_2", 1, HL, 1, 0, 1, 2'd0);
`endif
        checkOutput();
        applyStimulus(0, 1, 0, 0);
        expectAfter("mid_reset", 1, RH, 1, 0, 0, 2'd0);
        checkOutput();
        applyStimulus(1, 1, 0, 0);
        expectAfter("post_reset_hold", 9, RH, 1, 0, 0, 2'd0);
        expectAfter("post_reset_run",  1, RN, 0, 1, 0, 2'd0);
        checkOutput();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
